// File: rtl/saturn_bus_fabric.sv
// ---------------------------------------------------------------------------
// saturn_bus_fabric
// Bus fabric between the saturn bus controller and NUM_SLAVES memory-mapped
// devices. It owns the 4-phase one-hot sequencer and the bus cycle counter,
// drives the configuration daisy chain, returns the selected slave nibble to
// the controller, and flags/counts bus contention. Slot 0 is the default
// device (ROM): it is never part of the daisy chain and drives the bus
// whenever no other slot is active.
//
// Ports
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_clk_en             global clock enable
//   i_debug_cycle        debug stall, freezes phases and counter
//   i_ctrl_bus_clk_en    controller bus strobe request
//   i_ctrl_halt          controller halt request (ORed into o_halt)
//   i_slave_nibble       slot k nibble in bits [4k+3:4k]
//   i_slave_active       slot k claims the access (bit 0 ignored)
//   i_slave_daisy        daisy-out of slot k (bit 0 ignored)
//   o_slave_daisy        daisy-in to slot k (bit 0 tied 0)
//   o_bus_clk_en         i_clk_en & i_ctrl_bus_clk_en
//   o_bus_nibble_in      nibble returned to the controller
//   o_phases / o_phase   one-hot / binary phase, o_phase_0 = o_phases[0]
//   o_cycle_ctr          completed bus cycles
//   o_halt               sticky fabric halt | i_ctrl_halt
//   o_contention         more than one of slots 1..N-1 active this cycle
//   o_cont_count         saturating contention count
// ---------------------------------------------------------------------------
module saturn_bus_fabric #(
   parameter int NUM_SLAVES  = 4,
   parameter int CTR_W       = 32,
   parameter int HALT_CYCLE  = 0,
   parameter int HALT_FREEZE = 1,
   parameter int REG_RETURN  = 0,
   parameter int CONT_W      = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_clk_en,
   input  logic                    i_debug_cycle,
   input  logic                    i_ctrl_bus_clk_en,
   input  logic                    i_ctrl_halt,
   input  logic [4*NUM_SLAVES-1:0] i_slave_nibble,
   input  logic [NUM_SLAVES-1:0]   i_slave_active,
   input  logic [NUM_SLAVES-1:0]   i_slave_daisy,
   output logic [NUM_SLAVES-1:0]   o_slave_daisy,
   output logic                    o_bus_clk_en,
   output logic [3:0]              o_bus_nibble_in,
   output logic [3:0]              o_phases,
   output logic [1:0]              o_phase,
   output logic                    o_phase_0,
   output logic [CTR_W-1:0]        o_cycle_ctr,
   output logic                    o_halt,
   output logic                    o_contention,
   output logic [CONT_W-1:0]       o_cont_count
);

   logic [3:0]        phases_reg;
   logic [CTR_W-1:0]  ctr_reg;
   logic              fab_halt_reg;
   logic [CONT_W-1:0] cont_reg;
   logic              adv;
   logic              halt_hit;
   logic [3:0]        sel_nibble;
   logic [4:0]        active_cnt;

   // Slot 0 never takes part in arbitration or the daisy chain.
   logic unused_slot0;
   assign unused_slot0 = i_slave_active[0] ^ i_slave_daisy[0];

   assign o_bus_clk_en = i_clk_en & i_ctrl_bus_clk_en;
   assign o_halt       = fab_halt_reg | i_ctrl_halt;
   assign adv          = i_clk_en & ~i_debug_cycle & ~((HALT_FREEZE != 0) & o_halt);
   assign halt_hit     = (HALT_CYCLE != 0) && (ctr_reg == CTR_W'(HALT_CYCLE));

   assign o_phases    = phases_reg;
   assign o_phase_0   = phases_reg[0];
   assign o_cycle_ctr = ctr_reg;
   assign o_cont_count = cont_reg;

   always_comb begin
      case (phases_reg)
         4'b0010: o_phase = 2'd1;
         4'b0100: o_phase = 2'd2;
         4'b1000: o_phase = 2'd3;
         default: o_phase = 2'd0;
      endcase
   end

   // Sequencer, cycle counter and sticky halt.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         phases_reg   <= 4'b0001;
         ctr_reg      <= '0;
         fab_halt_reg <= 1'b0;
      end else begin
         if (adv) begin
            phases_reg <= {phases_reg[2:0], phases_reg[3]};
            // A bus cycle completes when phase 3 advances back to phase 0.
            if (phases_reg[3])
               ctr_reg <= ctr_reg + CTR_W'(1);
         end
         if (halt_hit)
            fab_halt_reg <= 1'b1;
      end
   end

   // Return mux: the highest-index active slot wins, slot 0 is the default.
   always_comb begin
      sel_nibble = i_slave_nibble[3:0];
      for (int k = 1; k < NUM_SLAVES; k++) begin
         if (i_slave_active[k])
            sel_nibble = i_slave_nibble[4*k +: 4];
      end
   end

   always_comb begin
      active_cnt = '0;
      for (int k = 1; k < NUM_SLAVES; k++)
         active_cnt = active_cnt + 5'(i_slave_active[k]);
   end

   assign o_contention = (active_cnt > 5'd1);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         cont_reg <= '0;
      else if (o_bus_clk_en && o_contention && (cont_reg != '1))
         cont_reg <= cont_reg + CONT_W'(1);
   end

   // Daisy chain: the last slot is always enabled, each slot below takes the
   // daisy-out of the slot above it.
   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_daisy
         if (gi == 0) begin : g_rom
            assign o_slave_daisy[gi] = 1'b0;
         end else if (gi == NUM_SLAVES - 1) begin : g_top
            assign o_slave_daisy[gi] = 1'b1;
         end else begin : g_mid
            assign o_slave_daisy[gi] = i_slave_daisy[gi+1];
         end
      end
   endgenerate

   generate
      if (REG_RETURN != 0) begin : g_reg_ret
         logic [3:0] nibble_reg;
         always_ff @(posedge i_clk) begin
            if (i_reset)
               nibble_reg <= 4'h0;
            else if (o_bus_clk_en)
               nibble_reg <= sel_nibble;
         end
         assign o_bus_nibble_in = nibble_reg;
      end else begin : g_comb_ret
         assign o_bus_nibble_in = sel_nibble;
      end
   endgenerate

endmodule

// File: tb/tb_saturn_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_saturn_bus_fabric
// Two fabric instances share one stimulus stream:
//   dut_a: combinational return, no halt cycle, 3-bit counter (wraps), 8-bit
//          contention count.
//   dut_b: registered return, halt at cycle 3 with freeze, 4-bit counter,
//          2-bit contention count (saturates at 3).
// A driver applies stimulus, advances a reference model and queues the
// expected outputs; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_saturn_bus_fabric;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_en;
   logic          debug_cycle;
   logic          ctrl_bus_clk_en;
   logic          ctrl_halt;
   logic [4*N-1:0] slave_nibble;
   logic [N-1:0]  slave_active;
   logic [N-1:0]  slave_daisy;

   logic [N-1:0]  daisy_a, daisy_b;
   logic          bce_a, bce_b;
   logic [3:0]    nib_a, nib_b;
   logic [3:0]    phases_a, phases_b;
   logic [1:0]    phase_a, phase_b;
   logic          ph0_a, ph0_b;
   logic [2:0]    ctr_a;
   logic [3:0]    ctr_b;
   logic          halt_a, halt_b;
   logic          cont_a, cont_b;
   logic [7:0]    cc_a;
   logic [1:0]    cc_b;

   always #5 clk = ~clk;

   saturn_bus_fabric #(.NUM_SLAVES(N), .CTR_W(3), .HALT_CYCLE(0), .HALT_FREEZE(1),
                       .REG_RETURN(0), .CONT_W(8)) dut_a (
      .i_clk(clk), .i_reset(reset), .i_clk_en(clk_en), .i_debug_cycle(debug_cycle),
      .i_ctrl_bus_clk_en(ctrl_bus_clk_en), .i_ctrl_halt(ctrl_halt),
      .i_slave_nibble(slave_nibble), .i_slave_active(slave_active),
      .i_slave_daisy(slave_daisy), .o_slave_daisy(daisy_a), .o_bus_clk_en(bce_a),
      .o_bus_nibble_in(nib_a), .o_phases(phases_a), .o_phase(phase_a),
      .o_phase_0(ph0_a), .o_cycle_ctr(ctr_a), .o_halt(halt_a),
      .o_contention(cont_a), .o_cont_count(cc_a));

   saturn_bus_fabric #(.NUM_SLAVES(N), .CTR_W(4), .HALT_CYCLE(3), .HALT_FREEZE(1),
                       .REG_RETURN(1), .CONT_W(2)) dut_b (
      .i_clk(clk), .i_reset(reset), .i_clk_en(clk_en), .i_debug_cycle(debug_cycle),
      .i_ctrl_bus_clk_en(ctrl_bus_clk_en), .i_ctrl_halt(ctrl_halt),
      .i_slave_nibble(slave_nibble), .i_slave_active(slave_active),
      .i_slave_daisy(slave_daisy), .o_slave_daisy(daisy_b), .o_bus_clk_en(bce_b),
      .o_bus_nibble_in(nib_b), .o_phases(phases_b), .o_phase(phase_b),
      .o_phase_0(ph0_b), .o_cycle_ctr(ctr_b), .o_halt(halt_b),
      .o_contention(cont_b), .o_cont_count(cc_b));

   typedef struct {
      int         txn;
      logic [3:0] phases_a, phases_b;
      logic [1:0] phase_a, phase_b;
      logic [31:0] ctr_a, ctr_b;
      logic       halt_a, halt_b;
      logic       cont;
      logic [7:0] cc_a;
      logic [1:0] cc_b;
      logic [3:0] nib_a, nib_b;
      logic [3:0] daisy;
      logic       bce;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: phases and counter are derived from the number of
   // sequencer advances since reset.
   int unsigned m_adv_a, m_adv_b;
   bit          m_halt_b;
   int unsigned m_cc_a, m_cc_b;
   logic [3:0]  m_nib_b;

   function automatic logic [3:0] pick_nibble(logic [N-1:0] act, logic [4*N-1:0] nibs);
      for (int k = N - 1; k >= 1; k--)
         if (act[k]) return nibs[4*k +: 4];
      return nibs[3:0];
   endfunction

   task automatic model_step();
      bit          bus_en;
      bit          contend;
      int unsigned cur_ctr_b;
      if (reset) begin
         m_adv_a = 0; m_adv_b = 0; m_halt_b = 0;
         m_cc_a = 0;  m_cc_b = 0;  m_nib_b = 4'h0;
         return;
      end
      bus_en    = clk_en && ctrl_bus_clk_en;
      contend   = $countones(slave_active[N-1:1]) > 1;
      cur_ctr_b = (m_adv_b / 4) % 16;
      if (clk_en && !debug_cycle && !ctrl_halt) m_adv_a++;
      if (clk_en && !debug_cycle && !(ctrl_halt || m_halt_b)) m_adv_b++;
      if (cur_ctr_b == 3) m_halt_b = 1;
      if (bus_en && contend) begin
         if (m_cc_a < 255) m_cc_a++;
         if (m_cc_b < 3)   m_cc_b++;
      end
      if (bus_en) m_nib_b = pick_nibble(slave_active, slave_nibble);
   endtask

   function automatic exp_t model_outputs(int txn);
      exp_t e;
      e.txn      = txn;
      e.phases_a = 4'(1 << (m_adv_a % 4));
      e.phases_b = 4'(1 << (m_adv_b % 4));
      e.phase_a  = 2'(m_adv_a % 4);
      e.phase_b  = 2'(m_adv_b % 4);
      e.ctr_a    = (m_adv_a / 4) % 8;
      e.ctr_b    = (m_adv_b / 4) % 16;
      e.halt_a   = ctrl_halt;
      e.halt_b   = m_halt_b || ctrl_halt;
      e.cont     = $countones(slave_active[N-1:1]) > 1;
      e.cc_a     = 8'(m_cc_a);
      e.cc_b     = 2'(m_cc_b);
      e.nib_a    = pick_nibble(slave_active, slave_nibble);
      e.nib_b    = m_nib_b;
      e.daisy    = {1'b1, slave_daisy[3], slave_daisy[2], 1'b0};
      e.bce      = clk_en && ctrl_bus_clk_en;
      return e;
   endfunction

   task automatic chk(string name, int txn, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s txn=%0d actual=%h expected=%h", name, txn, act, expv);
      end
   endtask

   // Monitor: outputs are valid every cycle, compared on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("phases_a",  e.txn, 32'(phases_a), 32'(e.phases_a));
         chk("phases_b",  e.txn, 32'(phases_b), 32'(e.phases_b));
         chk("phase_a",   e.txn, 32'(phase_a),  32'(e.phase_a));
         chk("phase_b",   e.txn, 32'(phase_b),  32'(e.phase_b));
         chk("phase0_a",  e.txn, 32'(ph0_a),    32'(e.phases_a[0]));
         chk("phase0_b",  e.txn, 32'(ph0_b),    32'(e.phases_b[0]));
         chk("ctr_a",     e.txn, 32'(ctr_a),    e.ctr_a);
         chk("ctr_b",     e.txn, 32'(ctr_b),    e.ctr_b);
         chk("halt_a",    e.txn, 32'(halt_a),   32'(e.halt_a));
         chk("halt_b",    e.txn, 32'(halt_b),   32'(e.halt_b));
         chk("cont_a",    e.txn, 32'(cont_a),   32'(e.cont));
         chk("cont_b",    e.txn, 32'(cont_b),   32'(e.cont));
         chk("cnt_a",     e.txn, 32'(cc_a),     32'(e.cc_a));
         chk("cnt_b",     e.txn, 32'(cc_b),     32'(e.cc_b));
         chk("nibble_a",  e.txn, 32'(nib_a),    32'(e.nib_a));
         chk("nibble_b",  e.txn, 32'(nib_b),    32'(e.nib_b));
         chk("daisy_a",   e.txn, 32'(daisy_a),  32'(e.daisy));
         chk("daisy_b",   e.txn, 32'(daisy_b),  32'(e.daisy));
         chk("busclk_a",  e.txn, 32'(bce_a),    32'(e.bce));
         chk("busclk_b",  e.txn, 32'(bce_b),    32'(e.bce));
         $display("txn %0d rst=%0b en=%0b dbg=%0b act=%b ph=%h/%h ctr=%0d/%0d halt=%0b/%0b nib=%h/%h cnt=%0d/%0d",
                  e.txn, reset, clk_en, debug_cycle, slave_active, phases_a, phases_b,
                  ctr_a, ctr_b, halt_a, halt_b, nib_a, nib_b, cc_a, cc_b);
      end
   end

   initial begin
      reset = 1'b1; clk_en = 1'b0; debug_cycle = 1'b0; ctrl_bus_clk_en = 1'b0;
      ctrl_halt = 1'b0; slave_nibble = '0; slave_active = '0; slave_daisy = '0;

      for (int cyc = 0; cyc < 800; cyc++) begin
         @(posedge clk);
         model_step();
         #1;
         clk_en          = ($urandom_range(3) != 0);
         debug_cycle     = ($urandom_range(7) == 0);
         ctrl_bus_clk_en = $urandom_range(1);
         ctrl_halt       = ($urandom_range(15) == 0);
         slave_nibble    = 16'($urandom);
         slave_active    = 4'($urandom);
         slave_daisy     = 4'($urandom);
         reset           = (cyc >= 60) && ($urandom_range(63) == 0);
         if (cyc < 60) begin
            // Directed opening: reset, free run, debug stall, then a
            // contention burst with slots 1 and 2 active.
            reset       = (cyc < 2);
            clk_en      = 1'b1;
            ctrl_halt   = 1'b0;
            debug_cycle = (cyc >= 12 && cyc < 15);
            if (cyc >= 20 && cyc < 30) begin
               slave_active    = 4'b0110;
               slave_nibble    = 16'hABCD;
               ctrl_bus_clk_en = 1'b1;
            end
            if (cyc >= 30 && cyc < 34) begin
               slave_active    = 4'b0000;
               slave_daisy     = 4'b0111;
            end
         end
         exp_q.push_back(model_outputs(cyc));
      end

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
